// File: rtl/hpc3_mul_sched.sv
// Issue scheduler for an external HPC3 masked multiplier: pairs each operand request with one fresh randomness word and reorders nothing.
// Latency: issue registers operands onto out_mul_* at the handshake edge; result lands in the FIFO MUL_LATENCY+1 edges later.
// Backpressure: out_req_ready needs a buffered randomness word and a free FIFO credit (inflight + stored < FIFO_DEPTH).
module hpc3_mul_sched #(
    parameter int NUM_SHARES  = 3,
    parameter int BIT_WIDTH   = 1,
    parameter int MUL_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    // Randomness words per multiplication: one per share pair (NUM_SHARES >= 2).
    localparam int NUM_QUAD   = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
    input  logic                                  in_clock,
    input  logic                                  in_reset,
    input  logic                                  in_req_valid,
    output logic                                  out_req_ready,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  in_req_a,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  in_req_b,
    input  logic                                  in_rand_valid,
    output logic                                  out_rand_ready,
    input  logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]    in_rand_r,
    input  logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]    in_rand_p,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  out_mul_a,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  out_mul_b,
    output logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]    out_mul_r,
    output logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]    out_mul_p,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  in_mul_c,
    output logic                                  out_res_valid,
    input  logic                                  in_res_ready,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]  out_res_c,
    output logic                                  out_busy,
    output logic [15:0]                           out_starve_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold inflight + stored without wrapping.
    localparam int CW = $clog2(FIFO_DEPTH + MUL_LATENCY + 2) + 1;

    typedef logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] share_t;
    typedef logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]   quad_t;

    // Single-entry randomness buffer.
    logic                  rand_full;
    quad_t                 rand_r_q;
    quad_t                 rand_p_q;

    // Issue tracking: bit i set means an operation issued i+1 edges ago.
    logic [MUL_LATENCY:0]  vld_sr;
    logic [CW-1:0]         inflight;

    // Result FIFO.
    share_t                fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    logic                  rand_hs;
    logic                  issue;
    logic                  push;
    logic                  pop;

    assign fifo_empty     = (fifo_count == '0);
    assign fifo_full      = (fifo_count == CW'(FIFO_DEPTH));

    assign out_rand_ready = !rand_full;
    // Credits cover results still in the multiplier as well as stored ones, so a push always finds a slot.
    assign out_req_ready  = rand_full && ((inflight + fifo_count) < CW'(FIFO_DEPTH));

    assign rand_hs        = in_rand_valid && !rand_full;
    assign issue          = in_req_valid && out_req_ready;
    assign push           = vld_sr[MUL_LATENCY];
    assign pop            = out_res_valid && in_res_ready;

    assign out_res_valid  = !fifo_empty;
    assign out_res_c      = fifo_mem[rd_ptr];
    assign out_busy       = (inflight != '0) || !fifo_empty;

    // Inflight is the population count of the issue shift register.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= MUL_LATENCY; i++) begin
            inflight = inflight + CW'(vld_sr[i]);
        end
    end

    // Randomness buffer: filled by a rand handshake, emptied by an issue (never both in one cycle).
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            rand_full <= 1'b0;
            rand_r_q  <= '0;
            rand_p_q  <= '0;
        end else if (rand_hs) begin
            rand_full <= 1'b1;
            rand_r_q  <= in_rand_r;
            rand_p_q  <= in_rand_p;
        end else if (issue) begin
            rand_full <= 1'b0;
        end
    end

    // Multiplier input registers hold the last issued operation until the next issue.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            out_mul_a <= '0;
            out_mul_b <= '0;
            out_mul_r <= '0;
            out_mul_p <= '0;
        end else if (issue) begin
            out_mul_a <= in_req_a;
            out_mul_b <= in_req_b;
            out_mul_r <= rand_r_q;
            out_mul_p <= rand_p_q;
        end
    end

    // Valid shift register tracks each issued operation until its product is captured.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | (MUL_LATENCY + 1)'(issue);
        end
    end

    // FIFO storage needs no reset; only pointers and count define validity.
    always_ff @(posedge in_clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_mul_c;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Starvation counter: a request waiting on an empty randomness buffer, saturating.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            out_starve_cnt <= '0;
        end else if (in_req_valid && !rand_full && (out_starve_cnt != 16'hFFFF)) begin
            out_starve_cnt <= out_starve_cnt + 16'd1;
        end
    end

    // The credit rule makes a push into a full FIFO unreachable.
    fifo_no_overflow: assert property (@(posedge in_clock) disable iff (in_reset) !(push && fifo_full));

endmodule

// File: tb/tb_hpc3_mul_sched.sv
// Bench for hpc3_mul_sched: directed stimulus, transaction-level model checked every cycle, plus literal checks.
// The external multiplier is a one-cycle behavioural stand-in whose share XOR equals the unmasked product.
// All waits are fixed tick counts, so the run always terminates.
module tb_hpc3_mul_sched;

    localparam int NS = 3;
    localparam int BW = 1;
    localparam int ML = 1;
    localparam int FD = 4;
    localparam int Q  = NS * (NS - 1) / 2;

    typedef logic [NS-1:0][BW-1:0] sh_t;
    typedef logic [Q-1:0][BW-1:0]  rq_t;
    typedef struct { rq_t r; rq_t p; } rword_t;
    typedef struct { sh_t c; int rdy; } res_t;

    logic        in_clock, in_reset;
    logic        in_req_valid, out_req_ready;
    sh_t         in_req_a, in_req_b;
    logic        in_rand_valid, out_rand_ready;
    rq_t         in_rand_r, in_rand_p;
    sh_t         out_mul_a, out_mul_b;
    rq_t         out_mul_r, out_mul_p;
    sh_t         in_mul_c, mul_q;
    logic        out_res_valid, in_res_ready;
    sh_t         out_res_c;
    logic        out_busy;
    logic [15:0] out_starve_cnt;

    hpc3_mul_sched #(
        .NUM_SHARES(NS), .BIT_WIDTH(BW), .MUL_LATENCY(ML), .FIFO_DEPTH(FD)
    ) dut (
        .in_clock(in_clock), .in_reset(in_reset),
        .in_req_valid(in_req_valid), .out_req_ready(out_req_ready),
        .in_req_a(in_req_a), .in_req_b(in_req_b),
        .in_rand_valid(in_rand_valid), .out_rand_ready(out_rand_ready),
        .in_rand_r(in_rand_r), .in_rand_p(in_rand_p),
        .out_mul_a(out_mul_a), .out_mul_b(out_mul_b),
        .out_mul_r(out_mul_r), .out_mul_p(out_mul_p),
        .in_mul_c(in_mul_c),
        .out_res_valid(out_res_valid), .in_res_ready(in_res_ready),
        .out_res_c(out_res_c), .out_busy(out_busy),
        .out_starve_cnt(out_starve_cnt)
    );

    always #5 in_clock = ~in_clock;

    // Functional stand-in for the masked multiplier: cross products plus masks that cancel pairwise.
    function automatic sh_t mulf(input sh_t a, input sh_t b, input rq_t r, input rq_t p);
        sh_t c;
        for (int i = 0; i < NS; i++) begin
            c[i] = r[i % Q] ^ r[(i + 1) % Q] ^ p[i % Q] ^ p[(i + 1) % Q];
            for (int j = 0; j < NS; j++) c[i] = c[i] ^ (a[i] & b[j]);
        end
        return c;
    endfunction

    function automatic logic [BW-1:0] xor_shares(input sh_t s);
        logic [BW-1:0] x = '0;
        for (int i = 0; i < NS; i++) x = x ^ s[i];
        return x;
    endfunction

    // One-cycle multiplier pipeline driven from the scheduler's registered outputs.
    always @(posedge in_clock) mul_q <= mulf(out_mul_a, out_mul_b, out_mul_r, out_mul_p);
    assign in_mul_c = mul_q;

    int cmp_count = 0;
    int err_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state.
    rword_t      rq[$];
    res_t        pend[$];
    logic [15:0] m_starve;
    sh_t         e_mul_a, e_mul_b;
    rq_t         e_mul_r, e_mul_p;
    int          edge_no = 0;
    int          dut_issues = 0;
    int          dut_pops = 0;
    logic        rand_taken = 1'b0;
    logic [5:0]  rword = 6'h05;

    // Runs at the falling edge: compare against the model, then advance it for the coming rising edge.
    task automatic model_step();
        logic   e_rand_rdy, e_req_rdy, e_res_vld, e_busy;
        rword_t w;
        if (in_reset) begin
            rq.delete();
            pend.delete();
            m_starve = '0;
            e_mul_a = '0; e_mul_b = '0; e_mul_r = '0; e_mul_p = '0;
            return;
        end
        e_rand_rdy = (rq.size() == 0);
        e_req_rdy  = (rq.size() != 0) && (pend.size() < FD);
        e_res_vld  = (pend.size() != 0) && (pend[0].rdy <= edge_no);
        e_busy     = (pend.size() != 0);
        check("m_rand_ready", out_rand_ready, e_rand_rdy);
        check("m_req_ready", out_req_ready, e_req_rdy);
        check("m_res_valid", out_res_valid, e_res_vld);
        check("m_busy", out_busy, e_busy);
        check("m_starve", out_starve_cnt, m_starve);
        check("m_mul_a", out_mul_a, e_mul_a);
        check("m_mul_b", out_mul_b, e_mul_b);
        check("m_mul_r", out_mul_r, e_mul_r);
        check("m_mul_p", out_mul_p, e_mul_p);
        if (e_res_vld) check("m_res_c", out_res_c, pend[0].c);
        if (in_req_valid && out_req_ready) dut_issues++;
        if (out_res_valid && in_res_ready) dut_pops++;
        if (in_req_valid && (rq.size() == 0) && (m_starve != 16'hFFFF)) m_starve = m_starve + 16'd1;
        if (e_res_vld && in_res_ready) void'(pend.pop_front());
        if (in_rand_valid && e_rand_rdy) begin
            rq.push_back('{r: in_rand_r, p: in_rand_p});
            rand_taken = 1'b1;
        end else if (in_req_valid && e_req_rdy) begin
            w = rq.pop_front();
            // Issue at edge E is stored at E+ML+1 and visible after it.
            pend.push_back('{c: mulf(in_req_a, in_req_b, w.r, w.p), rdy: edge_no + ML + 2});
            e_mul_a = in_req_a; e_mul_b = in_req_b; e_mul_r = w.r; e_mul_p = w.p;
        end
    endtask

    // One clock: model at the falling edge, then inputs settle 1 time unit after the rising edge.
    task automatic tick();
        @(negedge in_clock);
        model_step();
        @(posedge in_clock);
        edge_no++;
        #1;
        if (rand_taken) begin
            rand_taken = 1'b0;
            rword = rword + 6'd7;
        end
        in_rand_r = rword[2:0];
        in_rand_p = rword[5:3];
    endtask

    int base, pbase;

    initial begin
        in_clock = 1'b0; in_reset = 1'b1;
        in_req_valid = 1'b0; in_req_a = '0; in_req_b = '0;
        in_rand_valid = 1'b0; in_res_ready = 1'b0;
        in_rand_r = rword[2:0]; in_rand_p = rword[5:3];
        #2;
        check("rst_req_ready", out_req_ready, 1'b0);
        check("rst_rand_ready", out_rand_ready, 1'b1);
        check("rst_res_valid", out_res_valid, 1'b0);
        check("rst_busy", out_busy, 1'b0);
        check("rst_starve", out_starve_cnt, 16'h0);
        check("rst_mul_a", out_mul_a, '0);
        repeat (2) tick();
        in_reset = 1'b0;
        tick();

        // Single op: a=101, b=011, both share-XORs are 0 so the product is 0.
        in_rand_valid = 1'b1; tick(); in_rand_valid = 1'b0;
        in_req_valid = 1'b1; in_req_a = 3'b101; in_req_b = 3'b011; tick(); in_req_valid = 1'b0;
        check("op1_mul_a", out_mul_a, 3'b101);
        check("op1_mul_b", out_mul_b, 3'b011);
        check("op1_vld_t0", out_res_valid, 1'b0);
        tick();
        check("op1_vld_t1", out_res_valid, 1'b0);
        tick();
        check("op1_vld_t2", out_res_valid, 1'b1);
        check("op1_xor", xor_shares(out_res_c), 1'b0);
        in_res_ready = 1'b1; tick(); in_res_ready = 1'b0;
        check("op1_popped", out_res_valid, 1'b0);

        // Single op: a=111, b=001, product 1&1 = 1.
        in_rand_valid = 1'b1; tick(); in_rand_valid = 1'b0;
        in_req_valid = 1'b1; in_req_a = 3'b111; in_req_b = 3'b001; tick(); in_req_valid = 1'b0;
        repeat (2) tick();
        check("op2_vld", out_res_valid, 1'b1);
        check("op2_xor", xor_shares(out_res_c), 1'b1);
        in_res_ready = 1'b1; tick();

        // Back-to-back with randomness always offered: one issue every 2 cycles.
        base = dut_issues;
        in_rand_valid = 1'b1; in_req_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_req_a = (NS * BW)'(k);
            in_req_b = (NS * BW)'(k * 3 + 1);
            tick();
        end
        in_rand_valid = 1'b0; in_req_valid = 1'b0;
        check("b2b_issues", dut_issues - base, 8);
        repeat (6) tick();
        check("b2b_idle", out_busy, 1'b0);

        // Result sink stalled: exactly FD ops issue, then drain in order.
        base = dut_issues;
        in_res_ready = 1'b0; in_rand_valid = 1'b1; in_req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_req_a = (NS * BW)'(k + 2);
            in_req_b = (NS * BW)'(7 - k);
            tick();
        end
        check("full_issues", dut_issues - base, FD);
        check("full_req_ready", out_req_ready, 1'b0);
        check("full_res_valid", out_res_valid, 1'b1);
        in_req_valid = 1'b0; in_rand_valid = 1'b0;
        pbase = dut_pops;
        in_res_ready = 1'b1;
        repeat (8) tick();
        check("drain_pops", dut_pops - pbase, FD);
        check("drain_busy", out_busy, 1'b0);

        // Reset mid-operation with one result stored and one in the multiplier.
        in_res_ready = 1'b0; in_rand_valid = 1'b1; in_req_valid = 1'b1;
        in_req_a = 3'b110; in_req_b = 3'b101;
        repeat (3) tick();
        check("pre_rst_busy", out_busy, 1'b1);
        check("pre_rst_res_valid", out_res_valid, 1'b1);
        in_req_valid = 1'b0; in_rand_valid = 1'b0;
        pbase = dut_pops;
        #2 in_reset = 1'b1;
        #1;
        check("arst_req_ready", out_req_ready, 1'b0);
        check("arst_rand_ready", out_rand_ready, 1'b1);
        check("arst_res_valid", out_res_valid, 1'b0);
        check("arst_busy", out_busy, 1'b0);
        check("arst_mul_a", out_mul_a, '0);
        check("arst_mul_r", out_mul_r, '0);
        repeat (2) tick();
        in_reset = 1'b0;
        in_res_ready = 1'b1;
        repeat (6) tick();
        check("post_rst_pops", dut_pops - pbase, 0);
        check("post_rst_busy", out_busy, 1'b0);

        // Starvation: requests with no randomness.
        base = dut_issues;
        in_req_valid = 1'b1; in_rand_valid = 1'b0;
        repeat (10) tick();
        check("starve_10", out_starve_cnt, 16'd10);
        check("starve_no_issue", dut_issues - base, 0);
        repeat (65525) tick();
        check("starve_sat", out_starve_cnt, 16'hFFFF);
        repeat (5) tick();
        check("starve_hold", out_starve_cnt, 16'hFFFF);
        in_req_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/hpc3_mul_sched.md
HPC3_MUL_SCHED -- requirements
Module: hpc3_mul_sched

Interface
Parameters:
REQ-001 SHALL have parameter NUM_SHARES, default 3: number of Boolean shares per operand.
REQ-002 SHALL have parameter BIT_WIDTH, default 1: width of one share.
REQ-003 SHALL have parameter MUL_LATENCY, default 1: cycles from registered multiplier inputs to valid multiplier output.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries, power of two, at least 2.

Ports (T = BIT_WIDTH bits; Q = num_quad(NUM_SHARES) from aes128_package):
REQ-005 SHALL have in_clock, input, 1: single clock, rising edge.
REQ-006 SHALL have in_reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have in_req_valid/out_req_ready, input/output, 1 each: operand request handshake.
REQ-008 SHALL have in_req_a and in_req_b, input, T[NUM_SHARES] each: shared operands.
REQ-009 SHALL have in_rand_valid/out_rand_ready, input/output, 1 each: randomness source handshake.
REQ-010 SHALL have in_rand_r and in_rand_p, input, T[Q] each: one fresh randomness word.
REQ-011 SHALL have out_mul_a and out_mul_b (T[NUM_SHARES]) and out_mul_r and out_mul_p (T[Q]), output: drive the external hpc3_mul.
REQ-012 SHALL have in_mul_c, input, T[NUM_SHARES]: hpc3_mul product shares.
REQ-013 SHALL have out_res_valid/in_res_ready, output/input, 1 each, and out_res_c, output, T[NUM_SHARES]: result handshake.
REQ-014 SHALL have out_busy, output, 1: operation in flight or FIFO non-empty.
REQ-015 SHALL have out_starve_cnt, output, 16: randomness-starvation counter.

Function
REQ-016 SHALL hold one randomness-buffer entry (r, p, full flag); out_rand_ready = !full; a rand handshake sets full and captures r and p.
REQ-017 SHALL assert out_req_ready only when the buffer is full and credits = inflight + fifo_count < FIFO_DEPTH.
REQ-018 SHALL issue on a req handshake: register a, b and the buffered r, p onto out_mul_* at that edge, clear full, and push a 1 into a MUL_LATENCY+1 stage valid shift register.
REQ-019 SHALL consume each randomness word for exactly one issue; r and p SHALL never be reused across operations.
REQ-020 SHALL hold out_mul_* at their last issued values when no issue occurs.
REQ-021 SHALL capture in_mul_c into the FIFO on the edge where the shift-register tail is 1, i.e. a result issued at edge t is written at edge t+MUL_LATENCY+1.
REQ-022 SHALL count inflight as the number of 1s in the shift register; a simultaneous issue and capture leaves inflight unchanged.
REQ-023 SHALL present the FIFO head on out_res_c with out_res_valid = !empty; pop on out_res_valid && in_res_ready.
REQ-024 SHALL not overflow the FIFO: the credit rule in REQ-017 guarantees a slot, and a push with the FIFO full is an assertion failure.
REQ-025 SHALL handle a simultaneous push and pop with the FIFO full or empty correctly; count is unchanged and order is preserved.
REQ-026 SHALL let a rand handshake refill the buffer on the edge after the issue that emptied it; the rand handshake and the issue are never in the same cycle.
REQ-027 SHALL increment out_starve_cnt on each cycle where in_req_valid && !full, saturating at 16'hFFFF.
REQ-028 SHALL drive out_busy = (inflight != 0) || !empty.

Reset
REQ-029 SHALL, while in_reset is high, asynchronously clear the buffer full flag, the shift register, FIFO pointers and count, out_starve_cnt, and zero all out_mul_* registers.
REQ-030 SHALL have these values in reset: out_req_ready=0, out_rand_ready=1, out_res_valid=0, out_busy=0.
REQ-031 SHALL discard in-flight and buffered results on reset mid-operation; no stale result SHALL appear after reset release.

Verification
REQ-032 SHALL cover a single op (NUM_SHARES=3, BIT_WIDTH=1, MUL_LATENCY=1): a rand word, then a=3'b101, b=3'b011 -> out_res_valid 2 cycles after issue, and XOR of the result shares = (XOR a)&(XOR b).
REQ-033 SHALL cover back-to-back ops with rand always valid: one issue every 2 cycles, every op carries a distinct (r, p), and results arrive in order.
REQ-034 SHALL cover in_res_ready=0: exactly FIFO_DEPTH=4 ops issue, then out_req_ready stays 0; raising in_res_ready drains 4 results in order.
REQ-035 SHALL cover starvation: in_req_valid=1 and in_rand_valid=0 for 10 cycles -> out_starve_cnt=10 and no issue; saturation is checked with a forced count near 16'hFFFF.
REQ-036 SHALL cover reset asserted asynchronously with 2 ops in flight: outputs take reset values immediately, and no result appears after release.
